// File: rtl/btb_update_ctrl.sv
// Branch target buffer update controller.
// Owns the single write port of the BTB/BHT tables: clears every entry after
// reset or flush, then arbitrates resolved-branch BHT updates against
// decode-stage tag/target updates, buffering up to two of the latter.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_CLEAR | sweep index 0..2**BTB_IDX_SIZE-1 writing empty entries
// ST_RUN   | predictor valid; EX BHT writes, then queued/bypassed ID writes
module btb_update_ctrl #(
   parameter int  WORD_SIZE    = 16,
   parameter int  BTB_IDX_SIZE = 8,
   localparam int TAG_W        = WORD_SIZE - BTB_IDX_SIZE
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    flush_req,
   input  logic                    id_upd_valid,
   input  logic [WORD_SIZE-1:0]    id_upd_pc,
   input  logic [WORD_SIZE-1:0]    id_upd_target,
   output logic                    id_upd_ready,
   input  logic                    ex_upd_valid,
   input  logic [WORD_SIZE-1:0]    ex_upd_pc,
   input  logic                    ex_upd_taken,
   output logic [BTB_IDX_SIZE-1:0] bht_rd_idx,
   input  logic [1:0]              bht_rd_data,
   output logic [1:0]              wr_op,
   output logic [BTB_IDX_SIZE-1:0] wr_idx,
   output logic [TAG_W-1:0]        wr_tag,
   output logic [WORD_SIZE-1:0]    wr_target,
   output logic [1:0]              wr_bht,
   output logic                    ready
);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   localparam logic [1:0] WR_NONE = 2'b00;
   localparam logic [1:0] WR_CLR  = 2'b01;
   localparam logic [1:0] WR_ID   = 2'b10;
   localparam logic [1:0] WR_BHT  = 2'b11;

   localparam logic [BTB_IDX_SIZE-1:0] IDX_ONE  = 1;
   localparam logic [BTB_IDX_SIZE-1:0] IDX_LAST = '1;

   state_e                  state_q, state_d;
   // Holds off the clear sweep until the first clock edge after reset release.
   logic                    started_q, started_d;
   logic [BTB_IDX_SIZE-1:0] clr_cnt_q, clr_cnt_d;

   logic [WORD_SIZE-1:0]    fifo_pc_q  [2];
   logic [WORD_SIZE-1:0]    fifo_pc_d  [2];
   logic [WORD_SIZE-1:0]    fifo_tgt_q [2];
   logic [WORD_SIZE-1:0]    fifo_tgt_d [2];
   logic                    fifo_wp_q, fifo_wp_d;
   logic                    fifo_rp_q, fifo_rp_d;
   logic [1:0]              fifo_cnt_q, fifo_cnt_d;

   logic                    run_ok;
   logic                    fifo_empty;
   logic                    fifo_full;
   logic                    deq;
   logic                    enq;
   logic                    id_acc;
   logic                    bypass;
   logic [1:0]              bht_next;
   logic                    ex_pc_unused;

   assign bht_rd_idx   = ex_upd_pc[BTB_IDX_SIZE-1:0];
   assign ex_pc_unused = ^ex_upd_pc[WORD_SIZE-1:BTB_IDX_SIZE];

   assign ready        = (state_q == ST_RUN);
   assign run_ok       = (state_q == ST_RUN) && !flush_req;
   assign fifo_empty   = (fifo_cnt_q == 2'd0);
   assign fifo_full    = (fifo_cnt_q == 2'd2);
   // EX owns the port whenever valid, so the FIFO head drains only on EX-idle cycles.
   assign deq          = run_ok && !ex_upd_valid && !fifo_empty;
   assign id_upd_ready = run_ok && (!fifo_full || deq);
   assign id_acc       = id_upd_valid && id_upd_ready;
   assign bypass       = id_acc && !ex_upd_valid && fifo_empty;
   assign enq          = id_acc && !bypass;

   // 2-bit saturating counter update for the resolved branch.
   always_comb begin
      bht_next = bht_rd_data;
      if (ex_upd_taken) begin
         if (bht_rd_data != 2'd3) bht_next = bht_rd_data + 2'd1;
      end else begin
         if (bht_rd_data != 2'd0) bht_next = bht_rd_data - 2'd1;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_CLEAR;
      else          state_q <= state_d;
   end

   // Next-state: leave CLEAR after the last index unless a flush restarts the sweep.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_CLEAR: if (started_q && !flush_req && (clr_cnt_q == IDX_LAST)) state_d = ST_RUN;
         ST_RUN:   if (flush_req) state_d = ST_CLEAR;
         default:  state_d = ST_CLEAR;
      endcase
   end

   // Write-port outputs: clear sweep, or EX > FIFO head > bypassed ID.
   always_comb begin
      wr_op     = WR_NONE;
      wr_idx    = '0;
      wr_tag    = '0;
      wr_target = '0;
      wr_bht    = '0;
      case (state_q)
         ST_CLEAR: begin
            if (started_q) begin
               wr_op  = WR_CLR;
               wr_idx = clr_cnt_q;
               wr_bht = 2'b01;
            end
         end
         ST_RUN: begin
            if (!flush_req) begin
               if (ex_upd_valid) begin
                  wr_op  = WR_BHT;
                  wr_idx = ex_upd_pc[BTB_IDX_SIZE-1:0];
                  wr_bht = bht_next;
               end else if (!fifo_empty) begin
                  wr_op     = WR_ID;
                  wr_idx    = fifo_pc_q[fifo_rp_q][BTB_IDX_SIZE-1:0];
                  wr_tag    = fifo_pc_q[fifo_rp_q][WORD_SIZE-1:BTB_IDX_SIZE];
                  wr_target = fifo_tgt_q[fifo_rp_q];
               end else if (bypass) begin
                  wr_op     = WR_ID;
                  wr_idx    = id_upd_pc[BTB_IDX_SIZE-1:0];
                  wr_tag    = id_upd_pc[WORD_SIZE-1:BTB_IDX_SIZE];
                  wr_target = id_upd_target;
               end
            end
         end
         default: wr_op = WR_NONE;
      endcase
   end

   // Clear counter and ID FIFO next values.
   always_comb begin
      started_d  = 1'b1;
      clr_cnt_d  = clr_cnt_q;
      fifo_pc_d  = fifo_pc_q;
      fifo_tgt_d = fifo_tgt_q;
      fifo_wp_d  = fifo_wp_q;
      fifo_rp_d  = fifo_rp_q;
      fifo_cnt_d = fifo_cnt_q;
      if (state_q == ST_CLEAR) begin
         if (started_q) clr_cnt_d = flush_req ? '0 : clr_cnt_q + IDX_ONE;
      end else if (flush_req) begin
         clr_cnt_d  = '0;
         fifo_wp_d  = 1'b0;
         fifo_rp_d  = 1'b0;
         fifo_cnt_d = 2'd0;
      end else begin
         if (enq) begin
            fifo_pc_d[fifo_wp_q]  = id_upd_pc;
            fifo_tgt_d[fifo_wp_q] = id_upd_target;
            fifo_wp_d             = ~fifo_wp_q;
         end
         if (deq) fifo_rp_d = ~fifo_rp_q;
         case ({enq, deq})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
         endcase
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         started_q  <= 1'b0;
         clr_cnt_q  <= '0;
         fifo_pc_q  <= '{default: '0};
         fifo_tgt_q <= '{default: '0};
         fifo_wp_q  <= 1'b0;
         fifo_rp_q  <= 1'b0;
         fifo_cnt_q <= 2'd0;
      end else begin
         started_q  <= started_d;
         clr_cnt_q  <= clr_cnt_d;
         fifo_pc_q  <= fifo_pc_d;
         fifo_tgt_q <= fifo_tgt_d;
         fifo_wp_q  <= fifo_wp_d;
         fifo_rp_q  <= fifo_rp_d;
         fifo_cnt_q <= fifo_cnt_d;
      end
   end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Testbench for btb_update_ctrl: a behavioural predictor-port model produces
// the expected write each cycle; results are queued at drive time and
// compared against the DUT outputs on the falling edge.
module tb_btb_update_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        flush_req;
   logic        id_upd_valid;
   logic [15:0] id_upd_pc;
   logic [15:0] id_upd_target;
   logic        id_upd_ready;
   logic        ex_upd_valid;
   logic [15:0] ex_upd_pc;
   logic        ex_upd_taken;
   logic [7:0]  bht_rd_idx;
   logic [1:0]  bht_rd_data;
   logic [1:0]  wr_op;
   logic [7:0]  wr_idx;
   logic [7:0]  wr_tag;
   logic [15:0] wr_target;
   logic [1:0]  wr_bht;
   logic        ready;

   always #5 clk = ~clk;

   btb_update_ctrl #(.WORD_SIZE(16), .BTB_IDX_SIZE(8)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .flush_req     (flush_req),
      .id_upd_valid  (id_upd_valid),
      .id_upd_pc     (id_upd_pc),
      .id_upd_target (id_upd_target),
      .id_upd_ready  (id_upd_ready),
      .ex_upd_valid  (ex_upd_valid),
      .ex_upd_pc     (ex_upd_pc),
      .ex_upd_taken  (ex_upd_taken),
      .bht_rd_idx    (bht_rd_idx),
      .bht_rd_data   (bht_rd_data),
      .wr_op         (wr_op),
      .wr_idx        (wr_idx),
      .wr_tag        (wr_tag),
      .wr_target     (wr_target),
      .wr_bht        (wr_bht),
      .ready         (ready)
   );

   typedef struct {
      logic [1:0]  op;
      logic [7:0]  idx;
      logic [7:0]  tag;
      logic [15:0] tgt;
      logic [1:0]  bht;
      logic        rdy;
      logic        idr;
      logic [7:0]  rdidx;
   } exp_t;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] tgt;
   } idu_t;

   exp_t exp_q[$];
   idu_t m_fifo[$];
   bit   m_started;
   bit   m_clear;
   int   m_cnt;
   int   cyc;
   int   n_checks;
   int   n_fail;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d actual=%0h expected=%0h", tag, cyc, act, exp);
      end
   endtask

   // One clock cycle: drive inputs, predict this cycle's outputs, compare, advance the model.
   task automatic step(input logic rn, input logic fl,
                       input logic exv, input logic [15:0] expc, input logic ext,
                       input logic [1:0] bd,
                       input logic idv, input logic [15:0] idpc, input logic [15:0] idtg);
      exp_t e;
      exp_t g;
      logic idr;
      logic acc;
      logic byp;
      idu_t ent;
      reset_n       = rn;
      flush_req     = fl;
      ex_upd_valid  = exv;
      ex_upd_pc     = expc;
      ex_upd_taken  = ext;
      bht_rd_data   = bd;
      id_upd_valid  = idv;
      id_upd_pc     = idpc;
      id_upd_target = idtg;
      if (!rn) begin
         m_started = 1'b0;
         m_clear   = 1'b1;
         m_cnt     = 0;
         m_fifo.delete();
      end
      e = '{op: 2'b00, idx: 8'h00, tag: 8'h00, tgt: 16'h0000, bht: 2'b00,
            rdy: 1'b0, idr: 1'b0, rdidx: expc[7:0]};
      idr = 1'b0;
      if (m_clear) begin
         if (m_started) begin
            e.op  = 2'b01;
            e.idx = m_cnt[7:0];
            e.bht = 2'b01;
         end
      end else begin
         e.rdy = 1'b1;
         if (!fl) begin
            idr = (m_fifo.size() < 2) || (!exv && m_fifo.size() > 0);
            if (exv) begin
               e.op  = 2'b11;
               e.idx = expc[7:0];
               if (ext) e.bht = (bd == 2'd3) ? 2'd3 : bd + 2'd1;
               else     e.bht = (bd == 2'd0) ? 2'd0 : bd - 2'd1;
            end else if (m_fifo.size() > 0) begin
               e.op  = 2'b10;
               e.idx = m_fifo[0].pc[7:0];
               e.tag = m_fifo[0].pc[15:8];
               e.tgt = m_fifo[0].tgt;
            end else if (idv) begin
               e.op  = 2'b10;
               e.idx = idpc[7:0];
               e.tag = idpc[15:8];
               e.tgt = idtg;
            end
         end
      end
      e.idr = idr;
      exp_q.push_back(e);

      @(negedge clk);
      g = exp_q.pop_front();
      check_val("wr_op",        {30'd0, wr_op},        {30'd0, g.op});
      check_val("wr_idx",       {24'd0, wr_idx},       {24'd0, g.idx});
      check_val("wr_tag",       {24'd0, wr_tag},       {24'd0, g.tag});
      check_val("wr_target",    {16'd0, wr_target},    {16'd0, g.tgt});
      check_val("wr_bht",       {30'd0, wr_bht},       {30'd0, g.bht});
      check_val("ready",        {31'd0, ready},        {31'd0, g.rdy});
      check_val("id_upd_ready", {31'd0, id_upd_ready}, {31'd0, g.idr});
      check_val("bht_rd_idx",   {24'd0, bht_rd_idx},   {24'd0, g.rdidx});

      acc = idv && idr;
      byp = acc && !exv && (m_fifo.size() == 0);
      if (!rn) begin
         m_started = 1'b0;
      end else if (!m_started) begin
         m_started = 1'b1;
      end else if (m_clear) begin
         if (fl)                m_cnt = 0;
         else if (m_cnt == 255) begin m_clear = 1'b0; m_cnt = 0; end
         else                   m_cnt = m_cnt + 1;
      end else if (fl) begin
         m_clear = 1'b1;
         m_cnt   = 0;
         m_fifo.delete();
      end else begin
         if (!exv && m_fifo.size() > 0) m_fifo.pop_front();
         if (acc && !byp) begin
            ent.pc  = idpc;
            ent.tgt = idtg;
            m_fifo.push_back(ent);
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 16'h0000, 16'h0000);
   endtask

   task automatic ex_only(input logic [15:0] pc, input logic tk, input logic [1:0] bd);
      step(1'b1, 1'b0, 1'b1, pc, tk, bd, 1'b0, 16'h0000, 16'h0000);
   endtask

   initial begin
      reset_n       = 1'b0;
      flush_req     = 1'b0;
      id_upd_valid  = 1'b0;
      id_upd_pc     = '0;
      id_upd_target = '0;
      ex_upd_valid  = 1'b0;
      ex_upd_pc     = '0;
      ex_upd_taken  = 1'b0;
      bht_rd_data   = '0;
      m_started     = 1'b0;
      m_clear       = 1'b1;
      m_cnt         = 0;
      cyc           = 0;
      n_checks      = 0;
      n_fail        = 0;
      @(posedge clk);
      #1;

      // Held in reset: everything quiet.
      step(1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b1, 2'd1, 1'b1, 16'h1357, 16'h2468);
      step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 16'h0000, 16'h0000);

      // Release and sweep; EX/ID traffic during the sweep must be dropped.
      for (int i = 0; i < 260; i++)
         step(1'b1, 1'b0, (i % 7) == 3, 16'(16'h0100 + i), i[0], 2'(i), (i % 5) == 2,
              16'(16'h4000 + i), 16'(16'h8000 + i));

      // BHT saturating updates.
      ex_only(16'h1234, 1'b1, 2'd3);
      ex_only(16'h1234, 1'b0, 2'd0);
      ex_only(16'h5678, 1'b1, 2'd1);
      ex_only(16'h9A01, 1'b0, 2'd2);
      ex_only(16'hFFFF, 1'b1, 2'd0);
      ex_only(16'h00FE, 1'b0, 2'd3);

      // Lone ID update bypasses straight to the write port.
      step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b1, 16'hAB10, 16'h0042);

      // EX three cycles with ID every cycle: two enqueue, third stalls, then drain in order.
      step(1'b1, 1'b0, 1'b1, 16'h0A01, 1'b1, 2'd1, 1'b1, 16'h1111, 16'hA111);
      step(1'b1, 1'b0, 1'b1, 16'h0A02, 1'b0, 2'd2, 1'b1, 16'h2222, 16'hA222);
      step(1'b1, 1'b0, 1'b1, 16'h0A03, 1'b1, 2'd2, 1'b1, 16'h3333, 16'hA333);
      step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b1, 16'h3333, 16'hA333);
      idle(3);

      // Flush with a full FIFO: no write, queued entries discarded, full re-clear.
      step(1'b1, 1'b0, 1'b1, 16'h0B01, 1'b1, 2'd0, 1'b1, 16'h5555, 16'hA555);
      step(1'b1, 1'b0, 1'b1, 16'h0B02, 1'b0, 2'd3, 1'b1, 16'h6666, 16'hA666);
      step(1'b1, 1'b1, 1'b1, 16'h0B03, 1'b1, 2'd1, 1'b1, 16'h7777, 16'hA777);
      idle(258);

      // Flush in the middle of a sweep restarts it from index 0.
      step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 16'h0000, 16'h0000);
      idle(50);
      step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 16'h0000, 16'h0000);
      idle(258);

      // Mixed random traffic.
      for (int i = 0; i < 400; i++)
         step(1'b1, $urandom_range(0, 149) == 0, $urandom_range(0, 2) == 0, 16'($urandom),
              1'($urandom), 2'($urandom), $urandom_range(0, 1) == 1, 16'($urandom), 16'($urandom));

      // Reset asserted at clear index 100.
      step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 16'h0000, 16'h0000);
      if (m_clear) idle(100);
      else begin
         step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 16'h0000, 16'h0000);
         idle(100);
      end
      step(1'b0, 1'b0, 1'b1, 16'h2345, 1'b1, 2'd2, 1'b1, 16'h3456, 16'h4567);
      step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 16'h0000, 16'h0000);
      idle(260);
      step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b1, 16'hC0DE, 16'h0123);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
